// File: rtl/wb_line_buffer_pkg.sv
// rtl/wb_line_buffer_pkg.sv - shared constants and drain-state encoding for the write-back line buffer
//
// Purpose: MCB command codes, line geometry and the drain FSM state enum,
//          imported by the line buffer top module.
// Ports:   none (package).
package wb_line_buffer_pkg;

  // MCB command instruction codes
  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // A cache line is 16 x 128-bit beats; the MCB burst length field is beats-1
  localparam int         LINE_BEATS = 16;
  localparam logic [5:0] LINE_BL    = 6'd15;

  typedef enum logic [2:0] {
    DS_IDLE    = 3'd0,
    DS_REQ     = 3'd1,
    DS_DRAIN   = 3'd2,
    DS_CMD     = 3'd3,
    DS_RELEASE = 3'd4
  } drain_state_e;

endpackage

// File: rtl/wb_line_buffer_if.sv
// rtl/wb_line_buffer_if.sv - cache write-back beat stream into the line buffer
//
// Purpose: groups the cache-side beat handshake.
// Signals: in_valid/in_ready handshake, in_data beat payload, in_addr line
//          address (meaningful on beat 0), in_last marks the final beat.
// Modports: master = cache (source), slave = line buffer (sink).
interface wb_line_buffer_if #(
  parameter int DW = 128,
  parameter int AW = 16
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_addr;
  logic          in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_addr,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_addr,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/wb_line_ram.sv
// rtl/wb_line_ram.sv - line storage, one write port and one combinational read port
//
// Purpose: holds DEPTH beats of DW bits; written by the fill side, read
//          asynchronously by the drain side so write data is ready the same
//          cycle the drain pointer moves.
// Ports:   clk; we/waddr/wdata write port; raddr/rdata combinational read.
module wb_line_ram #(
  parameter int DEPTH = 32,
  parameter int DW    = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  // Storage contents are qualified by the pointers/count in the top, so the
  // array itself carries no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_line_buffer.sv
// rtl/wb_line_buffer.sv - write-back line buffer between cache eviction stream and MCB port 0
//
// Purpose: absorbs whole dirty lines from the cache at one beat per cycle,
//          then arbitrates for MCB port 0 and drains each line as 16 write
//          FIFO pushes followed by one write command. chk_hit lets the
//          read-miss path stall on a line that has not yet been released.
// Ports:   clk, reset (async, active-high)
//          fill        - cache beat stream (wb_line_buffer_if.slave)
//          chk_addr/chk_hit - combinational pending-line address match
//          lines_free  - number of free line slots
//          out_req/out_gnt  - port arbiter request / one-cycle grant
//          p0_wr_*     - MCB write FIFO push
//          p0_cmd_*    - MCB command push
//          done        - one-cycle pulse when a line is released
//          err         - sticky in_last / beat-count mismatch
module wb_line_buffer
  import wb_line_buffer_pkg::*;
#(
  parameter int LINES = 2,
  parameter int BEATS = LINE_BEATS,
  parameter int DW    = 128,
  parameter int AW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  wb_line_buffer_if.slave          fill,
  input  logic [AW-1:0]            chk_addr,
  output logic                     chk_hit,
  output logic [$clog2(LINES):0]   lines_free,
  output logic                     out_req,
  input  logic                     out_gnt,
  output logic                     p0_wr_en,
  output logic [DW-1:0]            p0_wr_data,
  input  logic                     p0_wr_full,
  output logic                     p0_cmd_en,
  output logic [2:0]               p0_cmd_instr,
  output logic [5:0]               p0_cmd_bl,
  output logic [29:0]              p0_cmd_byte_addr,
  output logic                     done,
  output logic                     err
);

  localparam int PW = $clog2(LINES);
  localparam int BW = $clog2(BEATS);
  localparam int CW = PW + 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [2:0] ST_IDLE    = DS_IDLE;
  localparam logic [2:0] ST_REQ     = DS_REQ;
  localparam logic [2:0] ST_DRAIN   = DS_DRAIN;
  localparam logic [2:0] ST_CMD     = DS_CMD;
  localparam logic [2:0] ST_RELEASE = DS_RELEASE;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [BW-1:0] wbeat_q, wbeat_d;
  logic [BW-1:0] rbeat_q, rbeat_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q [LINES];
  logic [AW-1:0] addr_d [LINES];

  logic accept;
  logic commit;
  logic release_line;

  // ---------------------------------------------------------------- fill side
  assign fill.in_ready = (count_q < CW'(LINES));
  assign accept        = fill.in_valid & fill.in_ready;
  assign commit        = accept & (wbeat_q == LAST_BEAT);

  always_comb begin
    wptr_d  = wptr_q;
    wbeat_d = wbeat_q;
    err_d   = err_q;
    addr_d  = addr_q;
    if (accept) begin
      if (wbeat_q == '0) begin
        addr_d[wptr_q] = fill.in_addr;
      end
      // in_last must coincide exactly with the final beat; the line is still
      // framed purely by beat count so a bad in_last cannot lose sync.
      if (fill.in_last != (wbeat_q == LAST_BEAT)) begin
        err_d = 1'b1;
      end
      if (commit) begin
        wbeat_d = '0;
        wptr_d  = wptr_q + 1'b1;
      end else begin
        wbeat_d = wbeat_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------- drain FSM
  always_comb begin
    state_d      = state_q;
    rbeat_d      = rbeat_q;
    rptr_d       = rptr_q;
    out_req      = 1'b0;
    p0_wr_en     = 1'b0;
    p0_cmd_en    = 1'b0;
    done         = 1'b0;
    release_line = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        out_req = 1'b1;
        if (out_gnt) begin
          state_d = ST_DRAIN;
          rbeat_d = '0;
        end
      end
      ST_DRAIN: begin
        // rbeat only advances on a real push, so p0_wr_data holds while full
        if (!p0_wr_full) begin
          p0_wr_en = 1'b1;
          rbeat_d  = rbeat_q + 1'b1;
          if (rbeat_q == LAST_BEAT) begin
            state_d = ST_CMD;
          end
        end
      end
      ST_CMD: begin
        p0_cmd_en = 1'b1;
        state_d   = ST_RELEASE;
      end
      ST_RELEASE: begin
        done         = 1'b1;
        release_line = 1'b1;
        rptr_d       = rptr_q + 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({commit, release_line})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // ------------------------------------------------------- pending-line check
  // A slot holds a committed, unreleased line when its distance ahead of
  // rptr is below count; the draining line stays counted until RELEASE.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < LINES; i++) begin
      if ((CW'(PW'(i) - rptr_q) < count_q) && (addr_q[i] == chk_addr)) begin
        chk_hit = 1'b1;
      end
    end
    // The filling line's address is captured on beat 0, so it is only valid
    // once at least one beat has landed.
    if ((wbeat_q != '0) && (addr_q[wptr_q] == chk_addr)) begin
      chk_hit = 1'b1;
    end
  end

  // ----------------------------------------------------------------- outputs
  assign lines_free       = CW'(LINES) - count_q;
  assign err              = err_q;
  assign p0_cmd_instr     = CMD_WR;
  assign p0_cmd_bl        = LINE_BL;
  assign p0_cmd_byte_addr = 30'({addr_q[rptr_q], 8'd0});

  wb_line_ram #(
    .DEPTH (LINES * BEATS),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr ({wptr_q, wbeat_q}),
    .wdata (fill.in_data),
    .raddr ({rptr_q, rbeat_q}),
    .rdata (p0_wr_data)
  );

  // --------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      wbeat_q <= '0;
      rbeat_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      wbeat_q <= wbeat_d;
      rbeat_q <= rbeat_d;
      count_q <= count_d;
      err_q   <= err_d;
      for (int i = 0; i < LINES; i++) begin
        addr_q[i] <= addr_d[i];
      end
    end
  end

endmodule
